// File: rtl/sap2_mem_pkg.sv
// sap2_mem_pkg: shared SAP-2 memory map and memory-sequencer state encoding
package sap2_mem_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} seqState_t;
  localparam logic [15:0] ROM_LAST_DEFAULT = 16'h007F;
  localparam logic [15:0] RAM_LAST_DEFAULT = 16'h00FF;
endpackage

// File: rtl/mar_mdr_sequencer.sv
// mar_mdr_sequencer: MAR/MDR memory-access sequencer (iReq/iWrite/iAddr/iWData in; oBusy/oDone/oFault/oRData status; oMemAddr/oMemRW/oMemEn/oMemLoad/oMemWData to memory, iMemData from memory)
module mar_mdr_sequencer
  import sap2_mem_pkg::*;
#(
  parameter logic [15:0] ROM_LAST    = ROM_LAST_DEFAULT,
  parameter logic [15:0] RAM_LAST    = RAM_LAST_DEFAULT,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [15:0] iAddr,
  input  logic [7:0]  iWData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oFault,
  output logic [7:0]  oRData,
  output logic [15:0] oMemAddr,
  output logic        oMemRW,
  output logic        oMemEn,
  output logic        oMemLoad,
  output logic [7:0]  oMemWData,
  input  logic [7:0]  iMemData
);
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
  seqState_t state, nextState;
  logic [15:0] mar;
  logic [7:0]  mdr;
  logic        faultFlag, writeFlag;
  logic [3:0]  waitCnt;
  logic        accept, illegal, lastAccess;
  assign accept     = state == IDLE && iReq;
  assign illegal    = iAddr > RAM_LAST || (iWrite && iAddr <= ROM_LAST);
  assign lastAccess = state == ACCESS && waitCnt == 4'd0;
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state     <= IDLE;
      mar       <= 16'h0000;
      mdr       <= 8'h00;
      faultFlag <= 1'b0;
      writeFlag <= 1'b0;
      waitCnt   <= 4'd0;
    end else begin
      state <= nextState;
      if (accept) begin
        mar       <= iAddr;
        writeFlag <= iWrite;
        faultFlag <= illegal;
        if (!illegal && iWrite) mdr <= iWData;
      end
      if (state == SETUP) waitCnt <= CNT_LOAD;
      else if (state == ACCESS && waitCnt != 4'd0) waitCnt <= waitCnt - 4'd1;
      if (lastAccess && !writeFlag) mdr <= iMemData;
    end
  end
  always_comb begin
    nextState = state == IDLE   ? (iReq ? (illegal ? DONE : SETUP) : IDLE) :
                state == SETUP  ? ACCESS :
                state == ACCESS ? (waitCnt == 4'd0 ? DONE : ACCESS) : IDLE;
    oBusy     = state == SETUP || state == ACCESS;
    oDone     = state == DONE;
    oFault    = state == DONE && faultFlag;
    oMemRW    = oBusy && writeFlag;
    oMemEn    = state == ACCESS && !writeFlag;
    oMemLoad  = state == ACCESS && writeFlag;
    oRData    = mdr;
    oMemWData = mdr;
    oMemAddr  = mar;
  end
endmodule
